sar_search_ctrl: RTL and testbench

//  Successive-approximation search controller. It drives the A operand of an external

---
 rtl/sar_pkg.sv | 21 ++
 rtl/sar_search_ctrl_if.sv | 42 ++++
 rtl/sar_search_ctrl.sv | 121 ++++++++++++
 tb/tb_sar_search_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared constants and state encoding for the successive-
//                approximation search controller.
//  Contents    : c_default_width - default operand/result width
//                state_t         - controller state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

   localparam int unsigned c_default_width = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SRCH = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sar_search_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_ctrl_if
//  Description : Bundle of control, comparator-flag and result signals between
//                the search controller and its environment.
//  Ports       : start/abort  - search control (environment -> controller)
//                Eq/Gt/Sm     - comparator flags for the current A
//                A            - trial value driven to the comparator
//                busy/done    - controller status
//                found/result - search outcome
//  Modports    : master - environment side; slave - controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface sar_search_ctrl_if
   import sar_pkg::*;
#(
   parameter int WIDTH = c_default_width
);

   logic             start;
   logic             abort;
   logic             Eq;
   logic             Gt;
   logic             Sm;
   logic [WIDTH-1:0] A;
   logic             busy;
   logic             done;
   logic             found;
   logic [WIDTH-1:0] result;

   modport master (
      output start, abort, Eq, Gt, Sm,
      input  A, busy, done, found, result
   );

   modport slave (
      input  start, abort, Eq, Gt, Sm,
      output A, busy, done, found, result
   );

endinterface
`default_nettype wire

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_ctrl
//  Description : Successive-approximation search controller. Drives trial
//                values (MSB first, one per clock) into an external magnitude
//                comparator and uses its flags to home in on a hidden target.
//                An Eq hit ends the search early.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - sar_search_ctrl_if.slave (start, abort, Eq, Gt, Sm in;
//                       A, busy, done, found, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  wire logic         clk,
   input  wire logic         rst,
   sar_search_ctrl_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_msb = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_found;

   state_t           w_nxt_state;
   logic [WIDTH-1:0] w_nxt_a;
   logic [WIDTH-1:0] w_nxt_mask;
   logic [WIDTH-1:0] w_nxt_acc;
   logic [WIDTH-1:0] w_nxt_result;
   logic             w_nxt_found;
   logic [WIDTH-1:0] w_acc_upd;
   logic [WIDTH-1:0] w_mask_sh;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_mask   <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_found  <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_a      <= w_nxt_a;
         r_mask   <= w_nxt_mask;
         r_acc    <= w_nxt_acc;
         r_result <= w_nxt_result;
         r_found  <= w_nxt_found;
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_a      = r_a;
      w_nxt_mask   = r_mask;
      w_nxt_acc    = r_acc;
      w_nxt_result = r_result;
      w_nxt_found  = r_found;
      w_mask_sh    = r_mask >> 1;
      // Sm and "no flag" both keep the bit; only Gt rejects it
      w_acc_upd    = bus.Gt ? r_acc : (r_acc | r_mask);

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_nxt_acc   = '0;
               w_nxt_mask  = c_msb;
               w_nxt_a     = c_msb;
               w_nxt_found = 1'b0;
               w_nxt_state = S_SRCH;
            end
         end

         S_SRCH: begin
            if (bus.abort) begin
               // A, result and found are left untouched
               w_nxt_state = S_IDLE;
            end else if (bus.Eq) begin
               // Eq outranks Gt/Sm, so contradictory flags still resolve
               w_nxt_result = r_a;
               w_nxt_found  = 1'b1;
               w_nxt_state  = S_DONE;
            end else if (r_mask[0]) begin
               w_nxt_result = w_acc_upd;
               w_nxt_found  = 1'b0;
               w_nxt_state  = S_DONE;
            end else begin
               w_nxt_acc  = w_acc_upd;
               w_nxt_mask = w_mask_sh;
               w_nxt_a    = w_acc_upd | w_mask_sh;
            end
         end

         S_DONE: begin
            w_nxt_state = S_IDLE;
         end

         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   assign bus.A      = r_a;
   assign bus.busy   = (r_state == S_SRCH);
   assign bus.done   = (r_state == S_DONE);
   assign bus.found  = r_found;
   assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search_ctrl
//  Description : Self-checking bench for sar_search_ctrl. A 4-bit magnitude
//                comparator against a bench-held target closes the loop; an
//                override path lets the bench force arbitrary flag patterns.
//                Expected trial sequences and outcomes come from a binary
//                search model written with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

   localparam int WIDTH = 4;

   logic clk;
   logic rst;
   int   tgt;
   bit   ovr;
   bit   ovr_eq, ovr_gt, ovr_sm;

   int   n_checks;
   int   n_fails;

   // Expected trial values and outcome for the current target
   int   exp_q[$];
   int   exp_res;
   bit   exp_fnd;

   sar_search_ctrl_if #(.WIDTH(WIDTH)) bus ();

   sar_search_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Comparator: A against the hidden target, or forced flags
   assign bus.Eq = ovr ? ovr_eq : (int'(bus.A) == tgt);
   assign bus.Gt = ovr ? ovr_gt : (int'(bus.A) >  tgt);
   assign bus.Sm = ovr ? ovr_sm : (int'(bus.A) <  tgt);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Binary search from the top bit down: guess acc+bit, keep the bit unless
   // the guess overshoots, stop as soon as a guess hits the target.
   task automatic model(input int b);
      int acc;
      int guess;
      exp_q   = {};
      acc     = 0;
      exp_fnd = 1'b0;
      for (int bitpos = WIDTH - 1; bitpos >= 0; bitpos--) begin
         guess = acc + (1 << bitpos);
         exp_q.push_back(guess);
         if (guess == b) begin
            exp_fnd = 1'b1;
            acc     = guess;
            break;
         end
         if (guess < b) acc = guess;
      end
      exp_res = acc;
   endtask

   // Full search from IDLE; leaves the controller back in IDLE
   task automatic run_search(input int b, input string tag);
      int idx;
      int steps;
      model(b);
      tgt        = b;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
      steps      = 1;
      idx        = 0;
      while (bus.busy === 1'b1 && idx < WIDTH + 2) begin
         if (idx < exp_q.size())
            check({tag, " trial A"}, bus.A, exp_q[idx]);
         idx++;
         step();
         steps++;
      end
      check({tag, " done"},    bus.done,   1);
      check({tag, " latency"}, steps,      exp_q.size() + 1);
      check({tag, " result"},  bus.result, exp_res);
      check({tag, " found"},   bus.found,  exp_fnd);
      step();
      check({tag, " done width"}, bus.done, 0);
   endtask

   initial begin
      int cyc;
      int busyc;
      int b;

      n_checks  = 0;
      n_fails   = 0;
      rst       = 1'b0;
      tgt       = 0;
      ovr       = 1'b0;
      ovr_eq    = 1'b0;
      ovr_gt    = 1'b0;
      ovr_sm    = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;

      // Reset values
      #2 rst = 1'b1;
      #2;
      check("reset A",      bus.A,      0);
      check("reset busy",   bus.busy,   0);
      check("reset done",   bus.done,   0);
      check("reset found",  bus.found,  0);
      check("reset result", bus.result, 0);
      #20 rst = 1'b0;
      step();

      // Directed searches: early exit, all-Gt, mixed path
      run_search(8,  "B8");
      run_search(0,  "B0");
      run_search(11, "B11");

      // Eq and Gt together on the first trial: Eq wins
      ovr = 1'b1; ovr_eq = 1'b1; ovr_gt = 1'b1; ovr_sm = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("EqGt first A", bus.A, 8);
      step();
      check("EqGt done",   bus.done,   1);
      check("EqGt result", bus.result, 8);
      check("EqGt found",  bus.found,  1);
      step();

      // No flag at all: every bit kept
      ovr_eq = 1'b0; ovr_gt = 1'b0; ovr_sm = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < WIDTH + 3) begin
         step();
         cyc++;
      end
      check("noflag latency", cyc,        WIDTH + 1);
      check("noflag result",  bus.result, 15);
      check("noflag found",   bus.found,  0);
      step();
      ovr = 1'b0;

      // Abort during the second trial: no done, outcome of previous run kept
      tgt = 7;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      check("abort 2nd trial A", bus.A, 4);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort busy",   bus.busy,   0);
      check("abort done",   bus.done,   0);
      check("abort A held", bus.A,      4);
      check("abort result", bus.result, 15);
      check("abort found",  bus.found,  0);
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.done === 1'b1 || bus.busy === 1'b1) cyc++;
      end
      check("abort stays idle", cyc, 0);

      // Asynchronous reset in the middle of a search
      tgt = 5;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst A",      bus.A,      0);
      check("midrst busy",   bus.busy,   0);
      check("midrst done",   bus.done,   0);
      check("midrst result", bus.result, 0);
      check("midrst found",  bus.found,  0);
      #2 rst = 1'b0;
      step();
      run_search(5, "after rst");

      // Sweep with start held high the whole time
      tgt = 0;
      bus.start = 1'b1;
      for (b = 0; b < 16; b++) begin
         model(b);
         cyc   = 0;
         busyc = 0;
         do begin
            step();
            cyc++;
            if (bus.busy === 1'b1) busyc++;
         end while (bus.done !== 1'b1 && cyc < WIDTH + 4);
         check($sformatf("sweep%0d done", b),   bus.done,   1);
         check($sformatf("sweep%0d result", b), bus.result, b);
         check($sformatf("sweep%0d found", b),  bus.found,  exp_fnd);
         check($sformatf("sweep%0d busy", b),   busyc,      exp_q.size());
         check($sformatf("sweep%0d cycles", b), cyc,
               (b == 0) ? exp_q.size() + 1 : exp_q.size() + 2);
         tgt = b + 1;
      end
      bus.start = 1'b0;
      step();
      step();

      // Random targets
      for (int i = 0; i < 20; i++) begin
         run_search(int'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
